// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch controller slice: FSM state
//   encoding and width, BCD digit limits and the "no target" value.
//   Optional target/alarm logic elsewhere is built only when
//   STOPWATCH_TARGET_EN is defined.
package stopwatch_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_DONE  = 3'd4
    } sw_state_e;

    localparam logic [3:0] BCD_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_ONES_MAX = 4'd9;

    localparam logic [7:0] NO_TARGET = 8'h00;

endpackage

// File: rtl/stopwatch_ctrl_bcd_dec.sv
// bcd_dec
//   Combinational two-digit BCD predecessor (value - 1) for a 00-59
//   seconds value, with a flag for digits outside the seconds range.
//   Ports:
//     value   in  8  BCD input, [7:4] tens, [3:0] ones
//     pred    out 8  BCD value one second earlier (ones 0 borrows from tens)
//     invalid out 1  tens > 5 or ones > 9
//   The result for 00 is meaningless; callers treat 00 as "no target".
module bcd_dec
    import stopwatch_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] pred,
    output logic       invalid
);

    logic [3:0] tens;
    logic [3:0] ones;

    assign tens = value[7:4];
    assign ones = value[3:0];

    assign invalid = (tens > BCD_TENS_MAX) || (ones > BCD_ONES_MAX);

    always_comb begin
        if (ones == 4'd0) begin
            pred = {tens - 4'd1, BCD_ONES_MAX};
        end else begin
            pred = {tens, ones - 4'd1};
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Start/pause/lap/reset control for a 00-59 BCD seconds counter.
//   Turns one-cycle button pulses into the counter's hold and clear
//   controls and selects the displayed value (live count or lap value).
//   With STOPWATCH_TARGET_EN defined, a target time latched at start
//   stops counting exactly at the target and raises alarm; otherwise
//   no target logic exists and alarm is tied low.
//   Ports:
//     clr       in  1  asynchronous active-high reset
//     clk_1s    in  1  1 Hz clock, rising edge
//     btn_ss    in  1  start/stop pulse
//     btn_lr    in  1  lap/reset pulse
//     count_in  in  8  BCD count from the seconds counter
//     target    in  8  BCD auto-stop time, latched when starting from IDLE
//     cnt_stay  out 1  counter hold (1 = freeze)
//     cnt_clr   out 1  one-cycle synchronous clear to the counter
//     disp      out 8  BCD value for the display
//     state     out 3  current FSM state
//     alarm     out 1  target reached
//   All outputs are registered so the counter's asynchronous hold input
//   is driven glitch-free.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] TGT_DEFAULT = 8'h00
) (
    input  logic               clr,
    input  logic               clk_1s,
    input  logic               btn_ss,
    input  logic               btn_lr,
    input  logic [7:0]         count_in,
    input  logic [7:0]         target,
    output logic               cnt_stay,
    output logic               cnt_clr,
    output logic [7:0]         disp,
    output logic [STATE_W-1:0] state,
    output logic               alarm
);

    sw_state_e  state_q;
    sw_state_e  state_d;
    logic [7:0] lap_q;
    logic [7:0] lap_d;
    logic       stay_d;
    logic       clr_d;
    logic       alarm_d;
    logic [7:0] disp_d;
    logic       hit;

`ifdef STOPWATCH_TARGET_EN
    logic [7:0] tgt_q;
    logic [7:0] tgt_pred;
    logic       tgt_invalid;

    bcd_dec u_bcd_dec (
        .value   (tgt_q),
        .pred    (tgt_pred),
        .invalid (tgt_invalid)
    );

    // Detect the second before the target: the counter steps onto the
    // target on the same edge the FSM enters DONE, so it never overshoots.
    assign hit = ((state_q == S_RUN) || (state_q == S_LAP)) &&
                 (tgt_q != NO_TARGET) && !tgt_invalid &&
                 (count_in == tgt_pred);

    always_ff @(posedge clk_1s or posedge clr) begin
        if (clr) begin
            tgt_q <= TGT_DEFAULT;
        end else if ((state_q == S_IDLE) && btn_ss) begin
            tgt_q <= target;
        end
    end
`else
    logic unused_target;

    assign unused_target = ^{target, TGT_DEFAULT};
    assign hit           = 1'b0;
`endif

    // State register plus the registered outputs.
    always_ff @(posedge clk_1s or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            lap_q    <= 8'h00;
            cnt_stay <= 1'b1;
            cnt_clr  <= 1'b0;
            alarm    <= 1'b0;
            disp     <= 8'h00;
        end else begin
            state_q  <= state_d;
            lap_q    <= lap_d;
            cnt_stay <= stay_d;
            cnt_clr  <= clr_d;
            alarm    <= alarm_d;
            disp     <= disp_d;
        end
    end

    // Next state: hit beats btn_ss, btn_ss beats btn_lr.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (btn_ss) state_d = S_RUN;
            end
            S_RUN: begin
                if (hit)         state_d = S_DONE;
                else if (btn_ss) state_d = S_PAUSE;
                else if (btn_lr) state_d = S_LAP;
            end
            S_LAP: begin
                if (hit)         state_d = S_DONE;
                else if (btn_ss) state_d = S_PAUSE;
                else if (btn_lr) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (btn_ss)      state_d = S_RUN;
                else if (btn_lr) state_d = S_IDLE;
            end
            S_DONE: begin
                if (btn_lr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // the registered outputs line up with the state they belong to.
    always_comb begin
        lap_d   = lap_q;
        if ((state_q == S_RUN) && (state_d == S_LAP)) begin
            lap_d = count_in;
        end
        stay_d  = !((state_d == S_RUN) || (state_d == S_LAP));
        clr_d   = (state_d == S_IDLE) && (state_q != S_IDLE);
`ifdef STOPWATCH_TARGET_EN
        alarm_d = (state_d == S_DONE);
`else
        alarm_d = 1'b0;
`endif
        disp_d  = (state_d == S_LAP) ? lap_d : count_in;
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam logic [7:0] TGT_DEFAULT = 8'h00;
    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_RUN   = 3'd1;
    localparam logic [2:0] M_PAUSE = 3'd2;
    localparam logic [2:0] M_LAP   = 3'd3;
    localparam logic [2:0] M_DONE  = 3'd4;

    logic       clr;
    logic       clk_1s;
    logic       btn_ss;
    logic       btn_lr;
    logic [7:0] count;
    logic [7:0] target;
    logic       cnt_stay;
    logic       cnt_clr;
    logic [7:0] disp;
    logic [2:0] state;
    logic       alarm;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    stopwatch_ctrl #(.TGT_DEFAULT(TGT_DEFAULT)) dut (
        .clr      (clr),
        .clk_1s   (clk_1s),
        .btn_ss   (btn_ss),
        .btn_lr   (btn_lr),
        .count_in (count),
        .target   (target),
        .cnt_stay (cnt_stay),
        .cnt_clr  (cnt_clr),
        .disp     (disp),
        .state    (state),
        .alarm    (alarm)
    );

    // ---------------- clock / reset ----------------
    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    // ---------------- helpers ----------------
    function automatic int bcd_secs(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int s);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(s / 10);
        o = 4'(s % 10);
        return {t, o};
    endfunction

    function automatic bit bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: the seconds counter ----------------
    always @(posedge clk_1s or posedge clr) begin
        if (clr)            count <= 8'h00;
        else if (cnt_clr)   count <= 8'h00;
        else if (!cnt_stay) count <= to_bcd((bcd_secs(count) + 1) % 60);
    end

    // ---------------- reference model ----------------
    logic [2:0] m_state;
    logic [7:0] m_lap;
    logic [7:0] m_tgt;
    logic       e_stay;
    logic       e_clr;
    logic       e_alarm;
    logic [7:0] e_disp;

    always @(posedge clk_1s or posedge clr) begin
        logic [2:0] nxt;
        logic [7:0] lap_n;
        bit         hit;
        bit         counting;
        if (clr) begin
            m_state <= M_IDLE;
            m_lap   <= 8'h00;
            m_tgt   <= TGT_DEFAULT;
            e_stay  <= 1'b1;
            e_clr   <= 1'b0;
            e_alarm <= 1'b0;
            e_disp  <= 8'h00;
        end else begin
            counting = (m_state == M_RUN) || (m_state == M_LAP);
`ifdef STOPWATCH_TARGET_EN
            hit = counting && bcd_ok(m_tgt) && bcd_secs(m_tgt) > 0 &&
                  bcd_secs(count) == bcd_secs(m_tgt) - 1;
`else
            hit = 1'b0;
`endif
            nxt   = m_state;
            lap_n = m_lap;
            if (hit) nxt = M_DONE;
            else if (m_state == M_IDLE  && btn_ss) nxt = M_RUN;
            else if (counting && btn_ss)           nxt = M_PAUSE;
            else if (m_state == M_PAUSE && btn_ss) nxt = M_RUN;
            else if (m_state == M_RUN   && btn_lr) begin nxt = M_LAP; lap_n = count; end
            else if (m_state == M_LAP   && btn_lr) nxt = M_RUN;
            else if (m_state == M_PAUSE && btn_lr) nxt = M_IDLE;
            else if (m_state == M_DONE  && btn_lr) nxt = M_IDLE;
            if (m_state == M_IDLE && btn_ss) m_tgt <= target;
            m_state <= nxt;
            m_lap   <= lap_n;
            e_stay  <= !(nxt == M_RUN || nxt == M_LAP);
            e_clr   <= (nxt == M_IDLE) && (m_state != M_IDLE);
            e_alarm <= (nxt == M_DONE);
            e_disp  <= (nxt == M_LAP) ? lap_n : count;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk_1s) begin
        if (cmp_en && !clr) begin
            check("state",    8'(state),    8'(m_state));
            check("cnt_stay", 8'(cnt_stay), 8'(e_stay));
            check("cnt_clr",  8'(cnt_clr),  8'(e_clr));
            check("alarm",    8'(alarm),    8'(e_alarm));
            check("disp",     disp,         e_disp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        @(negedge clk_1s);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
    endtask

    task automatic wait_count(input logic [7:0] v, input int budget);
        int n = 0;
        while (count !== v && n < budget) begin
            @(negedge clk_1s);
            n++;
        end
        if (count !== v) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_count: got %h required %h", count, v);
        end
    endtask

    task automatic back_to_idle();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (2) @(negedge clk_1s);
        check("idle_again", 8'(state), 8'(M_IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        clr    = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        target = 8'h00;
        repeat (2) @(negedge clk_1s);
        check("rst_state", 8'(state),    8'h00);
        check("rst_stay",  8'(cnt_stay), 8'h01);
        check("rst_clr",   8'(cnt_clr),  8'h00);
        check("rst_alarm", 8'(alarm),    8'h00);
        check("rst_disp",  disp,         8'h00);
        clr    = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk_1s);

        // start then pause at 07: counter still steps to 08, then holds
        pulse(1'b1, 1'b0);
        wait_count(8'h07, 20);
        pulse(1'b1, 1'b0);
        check("pause_state", 8'(state),    8'h02);
        check("pause_stay",  8'(cnt_stay), 8'h01);
        check("pause_count", count,        8'h08);
        repeat (5) @(negedge clk_1s);
        check("pause_hold",  count,        8'h08);
        check("pause_disp",  disp,         8'h08);

        // reset from PAUSE, then btn_lr in IDLE does nothing
        pulse(1'b0, 1'b1);
        check("rstp_state", 8'(state),   8'h00);
        check("rstp_clr",   8'(cnt_clr), 8'h01);
        @(negedge clk_1s);
        check("rstp_clr_end", 8'(cnt_clr), 8'h00);
        check("rstp_count",   count,       8'h00);
        @(negedge clk_1s);
        check("rstp_disp", disp, 8'h00);
        pulse(1'b0, 1'b1);
        check("idle_lr_state", 8'(state),   8'h00);
        check("idle_lr_clr",   8'(cnt_clr), 8'h00);

        // lap at 12, counter runs on to 20, lap again goes live
        pulse(1'b1, 1'b0);
        wait_count(8'h12, 20);
        pulse(1'b0, 1'b1);
        wait_count(8'h20, 20);
        check("lap_disp",  disp,        8'h12);
        check("lap_state", 8'(state),   8'h03);
        pulse(1'b0, 1'b1);
        check("live_disp",  disp,       8'h20);
        check("live_state", 8'(state),  8'h01);
        back_to_idle();

        // target 30: freeze at 30 with alarm; btn_ss ignored in DONE
        target = 8'h30;
        pulse(1'b1, 1'b0);
        wait_count(8'h30, 40);
`ifdef STOPWATCH_TARGET_EN
        check("tgt_state", 8'(state), 8'h04);
        check("tgt_alarm", 8'(alarm), 8'h01);
        repeat (3) @(negedge clk_1s);
        check("tgt_frozen", count, 8'h30);
        pulse(1'b1, 1'b0);
        check("tgt_ss_ign", 8'(state), 8'h04);
`else
        check("tgt_state", 8'(state), 8'h01);
        check("tgt_alarm", 8'(alarm), 8'h00);
        pulse(1'b1, 1'b0);
        check("tgt_pause", 8'(state), 8'h02);
`endif
        pulse(1'b0, 1'b1);
        check("tgt_rst_state", 8'(state),   8'h00);
        check("tgt_rst_clr",   8'(cnt_clr), 8'h01);
        repeat (2) @(negedge clk_1s);

        // target 01 hits on the first counted edge
        target = 8'h01;
        pulse(1'b1, 1'b0);
        @(negedge clk_1s);
        check("t01_count", count, 8'h01);
`ifdef STOPWATCH_TARGET_EN
        check("t01_state", 8'(state), 8'h04);
`else
        check("t01_state", 8'(state), 8'h01);
`endif
        back_to_idle();

        // both buttons together in RUN: pause only
        target = 8'h00;
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge clk_1s);
        pulse(1'b1, 1'b1);
        check("both_state", 8'(state), 8'h02);
        pulse(1'b0, 1'b1);
        repeat (2) @(negedge clk_1s);

        // invalid target 7A: wraps 59 -> 00 with no alarm
        target = 8'h7A;
        pulse(1'b1, 1'b0);
        wait_count(8'h59, 70);
        wait_count(8'h00, 5);
        check("inv_state", 8'(state), 8'h01);
        check("inv_alarm", 8'(alarm), 8'h00);
        back_to_idle();

        // async clr in LAP at 45
        target = 8'h00;
        pulse(1'b1, 1'b0);
        wait_count(8'h40, 50);
        pulse(1'b0, 1'b1);
        wait_count(8'h45, 10);
        check("pre_clr_state", 8'(state), 8'h03);
        #2 clr = 1'b1;
        #1;
        check("aclr_state", 8'(state),    8'h00);
        check("aclr_stay",  8'(cnt_stay), 8'h01);
        check("aclr_clr",   8'(cnt_clr),  8'h00);
        check("aclr_alarm", 8'(alarm),    8'h00);
        check("aclr_disp",  disp,         8'h00);
        #1 clr = 1'b0;
        @(negedge clk_1s);
        pulse(1'b1, 1'b0);
        check("clean_start", count, 8'h00);
        repeat (3) @(negedge clk_1s);
        check("clean_run", count, 8'h03);
        back_to_idle();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
